// File: rtl/hjbridge_pkg.sv
// Shared constants, status codes and FSM state encoding for the hjbridge host-to-register-bus bridge.
package hjbridge_pkg;

    localparam logic [7:0] CMD_RD    = 8'h52;
    localparam logic [7:0] CMD_WR    = 8'h57;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_ERR    = 8'h01;
    localparam logic [7:0] ST_TMO    = 8'h02;
    localparam logic [7:0] ST_BADCMD = 8'h03;

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned RD_BYTES   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDRL,
        S_ADDRH,
        S_DATA,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/hjbridge.sv
// Host byte-stream to register-bus initiator: parses a CMD/ADDR/DATA frame, issues one bus
// transaction and returns a status byte plus read data.
module hjbridge
    import hjbridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    output logic        rxready,
    output logic [7:0]  txdata,
    output logic        txvalid,
    input  logic        txready,
    output logic        regreq,
    output logic        regwr,
    output logic [11:0] regaddr,
    output logic [31:0] regwdata,
    input  logic        regack,
    input  logic        regerr,
    input  logic [31:0] regrdata
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       shreg, shreg_n;
    logic [TMO_W-1:0]  tmo, tmo_n;
    logic              rd_data, rd_data_n;
    logic              rxready_n, txvalid_n, regreq_n, regwr_n;
    logic [7:0]        txdata_n;
    logic [11:0]       regaddr_n;
    logic [31:0]       regwdata_n;
    logic              rx_fire, tx_fire;

    assign rx_fire = rxvalid && rxready;
    assign tx_fire = txvalid && txready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            tmo      <= '0;
            rd_data  <= 1'b0;
            rxready  <= 1'b0;
            txvalid  <= 1'b0;
            txdata   <= '0;
            regreq   <= 1'b0;
            regwr    <= 1'b0;
            regaddr  <= '0;
            regwdata <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            tmo      <= tmo_n;
            rd_data  <= rd_data_n;
            rxready  <= rxready_n;
            txvalid  <= txvalid_n;
            txdata   <= txdata_n;
            regreq   <= regreq_n;
            regwr    <= regwr_n;
            regaddr  <= regaddr_n;
            regwdata <= regwdata_n;
        end
    end

    // Next-state and next-output logic; every registered output is computed one cycle ahead.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        tmo_n      = tmo;
        rd_data_n  = rd_data;
        txvalid_n  = txvalid;
        txdata_n   = txdata;
        regwr_n    = regwr;
        regaddr_n  = regaddr;
        regwdata_n = regwdata;

        case (state)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rxdata == CMD_RD || rxdata == CMD_WR) begin
                        regwr_n = (rxdata == CMD_WR);
                        state_n = S_ADDRL;
                    end else begin
                        txvalid_n = 1'b1;
                        txdata_n  = ST_BADCMD;
                        rd_data_n = 1'b0;
                        cnt_n     = '0;
                        state_n   = S_RESP;
                    end
                end
            end
            S_ADDRL: begin
                if (rx_fire) begin
                    regaddr_n[7:0] = rxdata;
                    state_n        = S_ADDRH;
                end
            end
            S_ADDRH: begin
                if (rx_fire) begin
                    regaddr_n[11:8] = rxdata[3:0];
                    cnt_n           = '0;
                    state_n         = regwr ? S_DATA : S_REQ;
                end
            end
            S_DATA: begin
                // Data arrives LSB first, so shift each byte in from the top.
                if (rx_fire) begin
                    shreg_n = {rxdata, shreg[31:8]};
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt == DATA_LAST) begin
                        regwdata_n = {rxdata, shreg[31:8]};
                        state_n    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                tmo_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (regack) begin
                    txvalid_n = 1'b1;
                    txdata_n  = regerr ? ST_ERR : ST_OK;
                    rd_data_n = !regwr && !regerr;
                    shreg_n   = regrdata;
                    cnt_n     = '0;
                    state_n   = S_RESP;
                end else if (tmo == TMO_LAST) begin
                    txvalid_n = 1'b1;
                    txdata_n  = ST_TMO;
                    rd_data_n = 1'b0;
                    cnt_n     = '0;
                    state_n   = S_RESP;
                end else if (tmo != TMO_MAX) begin
                    tmo_n = tmo + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (!rd_data || cnt == RD_LAST) begin
                        txvalid_n = 1'b0;
                        state_n   = S_IDLE;
                    end else begin
                        txdata_n = shreg[7:0];
                        shreg_n  = {8'h00, shreg[31:8]};
                        cnt_n    = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        regreq_n  = (state_n == S_REQ);
        rxready_n = state_n inside {S_IDLE, S_ADDRL, S_ADDRH, S_DATA};
    end

endmodule

// File: tb/tb_hjbridge.sv
// Scoreboard bench for hjbridge: directed frames plus randomized traffic against a frame-level model.
module tb_hjbridge;
    import hjbridge_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxdata;
    logic        rxvalid;
    logic        rxready;
    logic [7:0]  txdata;
    logic        txvalid;
    logic        txready;
    logic        regreq;
    logic        regwr;
    logic [11:0] regaddr;
    logic [31:0] regwdata;
    logic        regack;
    logic        regerr;
    logic [31:0] regrdata;

    hjbridge #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rxdata(rxdata), .rxvalid(rxvalid), .rxready(rxready),
        .txdata(txdata), .txvalid(txvalid), .txready(txready),
        .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
        .regack(regack), .regerr(regerr), .regrdata(regrdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        bit          none;
        bit          late;
        bit          early;
        bit          err;
        int          d;
        logic [31:0] rd;
    } act_t;

    bus_t       exp_bus[$];
    act_t       acts[$];
    logic [7:0] exp_tx[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_stat_cyc = -1;
    int         last_hs = -1;
    bit         hold_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none t=%0t", name, $time);
    endtask

    function automatic act_t mk_act(bit none, bit late, bit early, bit err, int d, logic [31:0] rd);
        act_t a;
        a.none = none; a.late = late; a.early = early; a.err = err; a.d = d; a.rd = rd;
        return a;
    endfunction

    // Sink backpressure: random, or forced low by the directed hold test.
    initial begin
        txready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            txready = hold_low ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Register responder, driven by the action queued with each frame.
    initial begin
        act_t a;
        int   req_cyc;
        regack = 1'b0; regerr = 1'b0; regrdata = '0;
        forever begin
            @(negedge clk);
            if (regreq && !rst) begin
                req_cyc = cyc;
                if (acts.size() == 0) begin
                    flag("responder_no_action");
                end else begin
                    a = acts.pop_front();
                    if (a.early) begin
                        regack = 1'b1; regerr = 1'b1; regrdata = 32'hDEAD_BEEF;
                    end
                    @(posedge clk); #1;
                    regack = 1'b0; regerr = 1'b0;
                    if (a.none) begin
                        exp_stat_cyc = req_cyc + 1 + int'(TMO);
                        if (a.late) begin
                            repeat (19) begin @(posedge clk); #1; end
                            regack = 1'b1; regrdata = $urandom;
                            @(posedge clk); #1;
                            regack = 1'b0;
                        end
                    end else begin
                        repeat (a.d - 1) begin @(posedge clk); #1; end
                        regack = 1'b1; regerr = a.err; regrdata = a.rd;
                        exp_stat_cyc = cyc + 1;
                        @(posedge clk); #1;
                        regack = 1'b0; regerr = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: tx scoreboard, hold/latency rules and bus-request checks.
    initial begin
        bit         pv = 1'b0;
        bit         ph = 1'b0;
        bit         preq = 1'b0;
        logic [7:0] pd = '0;
        bus_t       b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (txvalid && !pv && exp_stat_cyc >= 0) begin
                    chk("status_latency", cyc, exp_stat_cyc);
                    exp_stat_cyc = -1;
                end
                if (ph) begin
                    chk("txvalid_hold", {31'b0, txvalid}, 32'd1);
                    chk("txdata_hold", {24'b0, txdata}, {24'b0, pd});
                end
                if (txvalid) chk("rxready_in_resp", {31'b0, rxready}, 32'd0);
                if (txvalid && txready) begin
                    if (exp_tx.size() == 0) flag("unexpected_tx");
                    else chk("txdata", {24'b0, txdata}, {24'b0, exp_tx.pop_front()});
                end
                if (regreq) begin
                    chk("regreq_width", {31'b0, preq}, 32'd0);
                    if (exp_bus.size() == 0) begin
                        flag("unexpected_regreq");
                    end else begin
                        b = exp_bus.pop_front();
                        chk("regwr", {31'b0, regwr}, {31'b0, b.wr});
                        chk("regaddr", {20'b0, regaddr}, {20'b0, b.addr});
                        if (b.wr) chk("regwdata", regwdata, b.wdata);
                        chk("regreq_latency", cyc, last_hs + 1);
                    end
                end
            end
            pv   = txvalid;
            ph   = txvalid && !txready;
            pd   = txdata;
            preq = regreq;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int hs);
        int n = 0;
        if (gaps) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        rxdata  = b;
        rxvalid = 1'b1;
        @(negedge clk);
        while (!rxready && n < 5000) begin @(negedge clk); n++; end
        if (!rxready) begin
            flag("rxready_stuck");
            $fatal(1, "rxready never asserted");
        end
        hs = cyc;
        @(posedge clk); #1;
        rxvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() != 0 || txvalid) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) flag("response_wait_expired");
        @(posedge clk); #1;
    endtask

    // Frame-level model: push the bus transaction and response the frame must produce, then send it.
    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wd,
                            input act_t a, input bit gaps, input bit rsp);
        int   hs;
        bus_t b;
        bit   good = (cmd == CMD_RD || cmd == CMD_WR);
        if (good) begin
            b.wr = (cmd == CMD_WR); b.addr = addr[11:0]; b.wdata = wd;
            exp_bus.push_back(b);
            acts.push_back(a);
            if (rsp) begin
                if (a.none)     exp_tx.push_back(ST_TMO);
                else if (a.err) exp_tx.push_back(ST_ERR);
                else begin
                    exp_tx.push_back(ST_OK);
                    if (!b.wr) for (int i = 0; i < 4; i++) exp_tx.push_back(a.rd[8*i +: 8]);
                end
            end
        end else if (rsp) begin
            exp_tx.push_back(ST_BADCMD);
        end
        send_byte(cmd, gaps, hs);
        if (!good) begin
            exp_stat_cyc = hs + 1;
        end else begin
            send_byte(addr[7:0], gaps, hs);
            send_byte(addr[15:8], gaps, hs);
            if (cmd == CMD_WR) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8], gaps, hs);
            last_hs = hs;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; rxvalid = 1'b0; rxdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rxready", {31'b0, rxready}, 32'd0);
        chk("rst_txvalid", {31'b0, txvalid}, 32'd0);
        chk("rst_txdata", {24'b0, txdata}, 32'd0);
        chk("rst_regreq", {31'b0, regreq}, 32'd0);
        chk("rst_regwr", {31'b0, regwr}, 32'd0);
        chk("rst_regaddr", {20'b0, regaddr}, 32'd0);
        chk("rst_regwdata", regwdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_frame(CMD_WR, 16'h000C, 32'hFFFF_FFFF, mk_act(0, 0, 0, 0, 3, 32'h0), 0, 1);
        wait_done();
        do_frame(CMD_RD, 16'hF008, 32'h0, mk_act(0, 0, 0, 0, 2, 32'h1234_5678), 0, 1);
        wait_done();
        do_frame(CMD_RD, 16'h0100, 32'h0, mk_act(0, 0, 0, 1, 1, 32'hCAFE_F00D), 0, 1);
        wait_done();
        do_frame(CMD_RD, 16'h0044, 32'h0, mk_act(1, 1, 0, 0, 1, 32'h0), 0, 1);
        wait_done();
        do_frame(CMD_RD, 16'h0FFF, 32'h0, mk_act(0, 0, 1, 0, int'(TMO), 32'hA5C3_0F81), 0, 1);
        wait_done();

        hold_low = 1'b1;
        do_frame(8'h41, 16'h0, 32'h0, mk_act(0, 0, 0, 0, 1, 32'h0), 0, 1);
        repeat (10) @(negedge clk);
        chk("badcmd_held_txvalid", {31'b0, txvalid}, 32'd1);
        chk("badcmd_held_txdata", {24'b0, txdata}, {24'b0, ST_BADCMD});
        @(posedge clk); #1;
        hold_low = 1'b0;
        wait_done();

        do_frame(CMD_RD, 16'h0ABC, 32'h0, mk_act(1, 0, 0, 0, 1, 32'h0), 0, 0);
        n = 0;
        while (exp_bus.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) flag("reset_test_regreq_wait_expired");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_rxready", {31'b0, rxready}, 32'd0);
        chk("wrst_txvalid", {31'b0, txvalid}, 32'd0);
        chk("wrst_txdata", {24'b0, txdata}, 32'd0);
        chk("wrst_regreq", {31'b0, regreq}, 32'd0);
        chk("wrst_regwr", {31'b0, regwr}, 32'd0);
        chk("wrst_regaddr", {20'b0, regaddr}, 32'd0);
        chk("wrst_regwdata", regwdata, 32'd0);
        repeat (25) @(posedge clk);
        #1 exp_stat_cyc = -1;
        do_frame(CMD_RD, 16'h0123, 32'h0, mk_act(0, 0, 0, 0, 4, 32'h89AB_CDEF), 0, 1);
        wait_done();

        for (int f = 0; f < 150; f++) begin
            logic [7:0] cmd;
            int         k = $urandom_range(9);
            act_t       a;
            if (k == 0) begin
                cmd = 8'($urandom);
                while (cmd == CMD_RD || cmd == CMD_WR) cmd = 8'($urandom);
            end else begin
                cmd = (k <= 4) ? CMD_RD : CMD_WR;
            end
            a = mk_act($urandom_range(9) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                       $urandom_range(4) == 0, int'($urandom_range(TMO, 1)), $urandom);
            do_frame(cmd, 16'($urandom), $urandom, a, 1, 1);
            wait_done();
        end
        repeat (30) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        flag("global_watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
